// File: rtl/alu4_result_queue.sv
// alu4_result_queue: registered output queue behind the 4-bit ALU.
// Captures {result, N, Z, C, V} into a small FIFO, presents the head entry
// over valid/ready, and retires popped entries into an NZCV status register
// with a sticky overflow bit.
// Optional feature: define ALU4_ZERO_CNT_EN to build the saturating counter
// of retired Z=1 entries (zero_cnt); otherwise zero_cnt is tied to 0.
module alu4_result_queue #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic             in_negative,
  input  logic             in_zero,
  input  logic             in_carry,
  input  logic             in_overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_nzcv,
  output logic [3:0]       status_nzcv,
  output logic             sticky_v,
  input  logic             sticky_clr,
  output logic [CNT_W-1:0] zero_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int ENT_W = WIDTH + 4;
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [ENT_W-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [OCC_W-1:0] count_reg;
  logic [DEPTH-1:0] wr_en;
  logic [ENT_W-1:0] head;
  logic             push;
  logic             pop;
  logic [3:0]       status_reg;
  logic             sticky_reg;

  // Wrap-around increment; DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Handshake: acceptance never looks at out_ready (no pass-through path).
  assign in_ready  = rst_n & (count_reg != FULL_OCC);
  assign out_valid = (count_reg != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Head entry straight from storage; flags are kept exactly as received.
  assign head       = mem_reg[rd_ptr_reg];
  assign out_result = head[ENT_W-1:4];
  assign out_nzcv   = head[3:0];

  // One write strobe per storage slot.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_wr_en
      assign wr_en[gi] = push & (wr_ptr_reg == PTR_W'(gi));
    end
  endgenerate

  // Storage is cleared on reset so the head reads 0 until the first push.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!rst_n) begin
        mem_reg[i] <= '0;
      end else if (wr_en[i]) begin
        mem_reg[i] <= {in_result, in_negative, in_zero, in_carry, in_overflow};
      end
    end
  end

  // Pointers and occupancy; simultaneous push and pop keeps count unchanged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= next_ptr(wr_ptr_reg);
      if (pop)  rd_ptr_reg <= next_ptr(rd_ptr_reg);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + OCC_W'(1);
        2'b01:   count_reg <= count_reg - OCC_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Retire: latch popped flags; a V=1 retire beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      status_reg <= '0;
      sticky_reg <= 1'b0;
    end else begin
      if (pop) status_reg <= out_nzcv;
      if (pop && out_nzcv[0]) begin
        sticky_reg <= 1'b1;
      end else if (sticky_clr) begin
        sticky_reg <= 1'b0;
      end
    end
  end

  assign status_nzcv = status_reg;
  assign sticky_v    = sticky_reg;

`ifdef ALU4_ZERO_CNT_EN
  logic [CNT_W-1:0] zero_cnt_reg;

  // Saturating count of Z=1 retires; clear with a Z=1 retire restarts at 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      zero_cnt_reg <= '0;
    end else if (pop && out_nzcv[2]) begin
      if (sticky_clr) begin
        zero_cnt_reg <= CNT_W'(1);
      end else if (zero_cnt_reg != '1) begin
        zero_cnt_reg <= zero_cnt_reg + CNT_W'(1);
      end
    end else if (sticky_clr) begin
      zero_cnt_reg <= '0;
    end
  end

  assign zero_cnt = zero_cnt_reg;
`else
  assign zero_cnt = '0;
`endif

endmodule

// File: tb/tb_alu4_result_queue.sv
// Self-checking bench for alu4_result_queue: queue-based reference model
// compared every cycle, plus directed literal expectations.
module tb_alu4_result_queue;

  localparam int WIDTH = 4;
  localparam int DEPTH = 2;
  localparam int CNT_W = 2;
  localparam int ZMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_result;
  logic             in_negative, in_zero, in_carry, in_overflow;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [3:0]       out_nzcv;
  logic [3:0]       status_nzcv;
  logic             sticky_v;
  logic             sticky_clr;
  logic [CNT_W-1:0] zero_cnt;

  int tests = 0;
  int fails = 0;

  alu4_result_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_negative(in_negative), .in_zero(in_zero), .in_carry(in_carry),
    .in_overflow(in_overflow),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_nzcv(out_nzcv), .status_nzcv(status_nzcv), .sticky_v(sticky_v),
    .sticky_clr(sticky_clr), .zero_cnt(zero_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] m_q[$];
  logic [7:0] m_e;
  logic [3:0] m_status;
  logic       m_sticky;
  int         m_zc;
  bit         m_init = 1'b0;
  bit         m_after_reset;
  bit         m_push, m_pop;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_q.delete();
      m_status      = 4'b0;
      m_sticky      = 1'b0;
      m_zc          = 0;
      m_after_reset = 1'b1;
      m_init        = 1'b1;
    end else begin
      m_push = in_valid && (m_q.size() < DEPTH);
      m_pop  = out_ready && (m_q.size() > 0);
      m_e    = 8'h00;
      if (m_pop) begin
        m_e      = m_q.pop_front();
        m_status = m_e[3:0];
      end
      if (m_pop && m_e[0]) m_sticky = 1'b1;
      else if (sticky_clr) m_sticky = 1'b0;
`ifdef ALU4_ZERO_CNT_EN
      if (m_pop && m_e[2]) m_zc = sticky_clr ? 1 : ((m_zc == ZMAX) ? ZMAX : m_zc + 1);
      else if (sticky_clr) m_zc = 0;
`endif
      if (m_push) begin
        m_q.push_back({in_result, in_negative, in_zero, in_carry, in_overflow});
        m_after_reset = 1'b0;
      end
    end
  end

  // Compare the DUT against the model once per cycle, mid-period.
  always @(negedge clk) begin
    if (m_init) begin
      chk("in_ready", int'(in_ready), int'(rst_n && (m_q.size() < DEPTH)));
      chk("out_valid", int'(out_valid), int'(m_q.size() > 0));
      if (m_q.size() > 0) begin
        chk("out_result", int'(out_result), int'(m_q[0][7:4]));
        chk("out_nzcv", int'(out_nzcv), int'(m_q[0][3:0]));
      end else if (m_after_reset) begin
        chk("out_result_rst", int'(out_result), 0);
        chk("out_nzcv_rst", int'(out_nzcv), 0);
      end
      chk("status_nzcv", int'(status_nzcv), int'(m_status));
      chk("sticky_v", int'(sticky_v), int'(m_sticky));
      chk("zero_cnt", int'(zero_cnt), m_zc);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [3:0] res, input logic [3:0] nzcv);
    in_result   = res;
    in_negative = nzcv[3];
    in_zero     = nzcv[2];
    in_carry    = nzcv[1];
    in_overflow = nzcv[0];
  endtask

  task automatic push1(input logic [3:0] res, input logic [3:0] nzcv);
    set_in(res, nzcv);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  int got[$];
  bit acc;
  int exp_z[5];

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sticky_clr = 1'b0;
    set_in(4'h0, 4'h0);
`ifdef ALU4_ZERO_CNT_EN
    exp_z = '{1, 2, 3, 3, 3};
`else
    exp_z = '{0, 0, 0, 0, 0};
`endif
    repeat (2) step();
    // Reset state
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_status", int'(status_nzcv), 0);
    chk("rst_out_result", int'(out_result), 0);
    rst_n = 1'b1;
    #1;
    chk("in_ready_after_rst", int'(in_ready), 1);
    step();

    // Single entry
    push1(4'b1010, 4'b1000);
    chk("t1_out_valid", int'(out_valid), 1);
    chk("t1_out_result", int'(out_result), 4'b1010);
    chk("t1_out_nzcv", int'(out_nzcv), 4'b1000);
    chk("t1_status_before", int'(status_nzcv), 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t1_status_after", int'(status_nzcv), 4'b1000);
    chk("t1_out_valid_after", int'(out_valid), 0);

    // Fill and back-pressure
    in_valid = 1'b1;
    set_in(4'd1, 4'b0000); step();
    set_in(4'd2, 4'b0010); step();
    chk("t2_full_in_ready", int'(in_ready), 0);
    set_in(4'd3, 4'b0000); step(); step();
    chk("t2_head_held", int'(out_result), 1);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) got.push_back(int'(out_result));
      acc = in_valid && in_ready;
      step();
      if (acc) in_valid = 1'b0;
    end
    out_ready = 1'b0;
    chk("t2_count_out", got.size(), 3);
    for (int i = 0; i < got.size() && i < 3; i++) chk("t2_order", got[i], i + 1);

    // Streaming push/pop at count=1
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_in(4'(i), {i[0], (i == 0), i[1], 1'b0});
      if (i > 0) begin
        chk("t3_lag_result", int'(out_result), i - 1);
        chk("t3_valid", int'(out_valid), 1);
        chk("t3_in_ready", int'(in_ready), 1);
      end
      step();
    end
    in_valid = 1'b0;
    step();
    chk("t3_drained", int'(out_valid), 0);

    // Sticky overflow (out_ready stays 1: each entry retires one cycle later)
    push1(4'd5, 4'b0001);
    step();
    chk("t4_sticky_set", int'(sticky_v), 1);
    chk("t4_status_v", int'(status_nzcv), 4'b0001);
    push1(4'd6, 4'b0000);
    step();
    chk("t4_sticky_hold", int'(sticky_v), 1);
    sticky_clr = 1'b1; step(); sticky_clr = 1'b0;
    chk("t4_sticky_clr", int'(sticky_v), 0);
    push1(4'd7, 4'b0001);
    sticky_clr = 1'b1; step(); sticky_clr = 1'b0;
    chk("t4_set_wins", int'(sticky_v), 1);

    // Reset mid-stream with two entries queued
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_in(4'd9, 4'b0101); step();
    set_in(4'd4, 4'b1001); step();
    in_valid = 1'b0;
    chk("t5_full", int'(in_ready), 0);
    rst_n = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("t5_in_ready_rst", int'(in_ready), 0);
    step();
    chk("t5_out_valid", int'(out_valid), 0);
    chk("t5_status", int'(status_nzcv), 0);
    chk("t5_sticky", int'(sticky_v), 0);
    rst_n = 1'b1;
    #1;
    chk("t5_in_ready_after", int'(in_ready), 1);
    step();

    // Zero-result counter
    for (int k = 0; k < 5; k++) begin
      push1(4'(k), 4'b0100);
      step();
      chk("t6_zero_cnt", int'(zero_cnt), exp_z[k]);
    end
    sticky_clr = 1'b1; step(); sticky_clr = 1'b0;
    chk("t6_zero_clr", int'(zero_cnt), 0);
    push1(4'd0, 4'b0100);
    sticky_clr = 1'b1; step(); sticky_clr = 1'b0;
`ifdef ALU4_ZERO_CNT_EN
    chk("t6_clr_with_z", int'(zero_cnt), 1);
`else
    chk("t6_clr_with_z", int'(zero_cnt), 0);
`endif
    out_ready = 1'b0;
    repeat (2) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
